obuf_reader: RTL and testbench
==============================

// Module: obuf_reader
// PURPOSE
//  Drains the read side of the camera output-buffer async FIFO (12-bit RGB444) in the system clock domain.
//  Writes each frame row-major into a double-buffered frame memory through a valid/ready write port.
//  Aligns to start-of-frame and flips the bank at each completed frame. Reports short frames and dropped pixels.
// PARAMETERS
//  DATA_WIDTH  12      pixel width (RGB444)
//  H_ACTIVE    640     pixels per line
//  V_ACTIVE    480     lines per frame
//  ADDR_WIDTH  19      frame-memory address width; must satisfy 2**ADDR_WIDTH >= H_ACTIVE*V_ACTIVE
// PORTS
//  i_clk         in   1           system clock; same clock as the FIFO read clock
//  i_rstn        in   1           active-low asynchronous reset
//  i_enable      in   1           capture enable
//  i_sof         in   1           1-cycle start-of-frame pulse, already synchronised to i_clk
//  o_obuf_rd     out  1           FIFO read enable
//  i_obuf_data   in   DATA_WIDTH  FIFO read data, valid the cycle after o_obuf_rd
//  i_obuf_empty  in   1           FIFO empty flag
//  o_mem_wr      out  1           write valid
//  i_mem_ready   in   1           write ready; a write occurs when o_mem_wr & i_mem_ready
//  o_mem_addr    out  ADDR_WIDTH  linear pixel address, row-major
//  o_mem_data    out  DATA_WIDTH  pixel data
//  o_bank        out  1           bank being written
//  o_frame_done  out  1           1-cycle pulse when the last pixel of a frame is written
//  o_err_short   out  1           1-cycle pulse when i_sof arrives mid-frame
//  o_drop        out  1           1-cycle pulse for each pixel discarded outside a frame
// BEHAVIOUR
//  Reset: all outputs 0, bank 0, pixel counter 0, skid buffer empty, FSM=IDLE.
//   Any FIFO data in flight at reset is lost.
//  FIFO read: o_obuf_rd = !i_obuf_empty & (skid_occupancy + reads_in_flight < 2). Never read when empty.
//   Data is captured into the skid buffer on the cycle after o_obuf_rd.
//  Memory write: the head skid entry drives o_mem_wr/o_mem_addr/o_mem_data.
//   Hold addr/data stable while o_mem_wr & !i_mem_ready.
//  Latency: o_obuf_rd to o_mem_wr is 2 cycles. Throughput is 1 pixel/clk with i_mem_ready=1 and FIFO non-empty.
//  FSM:
//   IDLE:     o_obuf_rd=0, i_sof ignored; i_enable=1 -> WAIT_SOF.
//   WAIT_SOF: FIFO is read; each popped pixel is discarded (pulses o_drop, no mem write);
//             i_sof -> ACTIVE with counter=0; i_enable=0 -> IDLE.
//   ACTIVE:   each accepted write increments the counter; addr = counter.
//             Accepting addr H_ACTIVE*V_ACTIVE-1 -> o_frame_done next cycle, o_bank toggles in the same cycle,
//             counter=0, -> WAIT_SOF (-> IDLE if i_enable=0).
//  Boundary conditions:
//   i_sof in ACTIVE before the last pixel: o_err_short pulse; counter=0; bank unchanged; stay ACTIVE.
//    Buffered pixels are written from addr 0.
//   i_sof in the same cycle as the last-pixel accept: frame completes normally (done, bank flip),
//    next state is ACTIVE, not WAIT_SOF; no o_err_short.
//   i_enable=0 in ACTIVE takes effect only at frame end.
//   Counter never exceeds H_ACTIVE*V_ACTIVE-1; the address never wraps inside a frame.
//   i_mem_ready=0 indefinitely: skid fills to 2, o_obuf_rd=0, no pixel is lost or duplicated.
// STRUCTURE
//  H_ACTIVE, V_ACTIVE and the pixel width live in the shared camera defines package, common with capture.
//   The FSM state encodings are local.
//  Sub-module obuf_skid2: 2-entry valid/ready skid buffer (DATA_WIDTH wide).
//   It exposes occupancy for the read-issue logic.
//   FSM, pixel counter and bank register live in obuf_reader.
// TESTING
//  1. Reset, enable, sof, then 307200 pixels streamed with ready=1
//     -> addr 0..307199 in order, 1 write/clk, frame_done once, bank 0->1.
//  2. ready toggling 1-of-3, FIFO never empty -> o_obuf_rd never asserted with skid full; data matches in order; no loss.
//  3. Pixels pushed before the first sof -> o_drop pulses once per pixel, no o_mem_wr;
//     the first post-sof pixel is written to addr 0.
//  4. sof after 1000 pixels -> o_err_short pulse, next write addr 0, bank unchanged.
//  5. sof coincident with the accept of addr 307199 -> frame_done, bank flips, next pixel written to addr 0 with no drop.
//  6. Reset asserted mid-frame with skid full -> all outputs 0 immediately; after release, FSM=IDLE and bank=0.

Source files
------------

// File: rtl/obuf_reader_pkg.sv
// Shared camera definitions, used by the capture side and the output-buffer reader.
// Holds the active picture geometry, the pixel width and the frame-memory address width.
// It also provides a small helper that gives the pixel count of one frame.
package obuf_reader_pkg;

    localparam int CAM_DATA_WIDTH = 12;   // RGB444
    localparam int CAM_H_ACTIVE   = 640;  // pixels per line
    localparam int CAM_V_ACTIVE   = 480;  // lines per frame
    localparam int CAM_ADDR_WIDTH = 19;   // 2**19 >= 640*480

    // Number of pixels in one frame, which is also one past the last linear address.
    function automatic int frame_pixels(input int h_active, input int v_active);
        return h_active * v_active;
    endfunction

endpackage

// File: rtl/obuf_skid2.sv
// Two-entry valid/ready skid buffer between the FIFO read port and the frame-memory write port.
// Ports:
//   i_clk, i_rstn          clock and active-low asynchronous reset
//   i_push, i_push_data    one word written per cycle while i_push is high; the caller never
//                          pushes into a buffer that stays full for that cycle
//   i_pop                  the consumer takes the head word this cycle (ignored when empty)
//   o_head_valid/_data     the oldest buffered word
//   o_occupancy            number of words held (0..2), used by the read-issue logic
module obuf_skid2
    import obuf_reader_pkg::*;
#(
    parameter int DATA_WIDTH = CAM_DATA_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic                  o_head_valid,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic [1:0]            o_occupancy
);

    logic [DATA_WIDTH-1:0] entry_q [2];
    logic [DATA_WIDTH-1:0] entry_d [2];
    logic [1:0]            count_q;
    logic [1:0]            count_d;
    logic [1:0]            count_after_pop;
    logic                  do_pop;

    always_comb begin
        entry_d[0]      = entry_q[0];
        entry_d[1]      = entry_q[1];
        do_pop          = i_pop && (count_q != 2'd0);
        count_after_pop = count_q - {1'b0, do_pop};
        // Popping shifts the second entry into the head slot.
        if (do_pop) begin
            entry_d[0] = entry_q[1];
        end
        // A push lands in the first free slot once the pop has been applied.
        if (i_push) begin
            if (count_after_pop == 2'd0) begin
                entry_d[0] = i_push_data;
            end else begin
                entry_d[1] = i_push_data;
            end
        end
        count_d = count_after_pop + {1'b0, i_push};
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            count_q    <= 2'd0;
        end else begin
            entry_q[0] <= entry_d[0];
            entry_q[1] <= entry_d[1];
            count_q    <= count_d;
        end
    end

    assign o_head_valid = (count_q != 2'd0);
    assign o_head_data  = entry_q[0];
    assign o_occupancy  = count_q;

endmodule

// File: rtl/obuf_reader.sv
// Drains the camera output-buffer FIFO into a double-buffered frame memory.
// Pixels are written row-major from linear address 0 after each start-of-frame; the bank
// flips when the last pixel of a frame is written. Pixels seen outside a frame are dropped.
// Ports:
//   i_clk, i_rstn                 system clock (also the FIFO read clock), async active-low reset
//   i_enable                      capture enable, sampled at frame boundaries while capturing
//   i_sof                         one-cycle start-of-frame pulse
//   o_obuf_rd, i_obuf_data,
//   i_obuf_empty                  FIFO read port; data is valid the cycle after o_obuf_rd
//   o_mem_wr, i_mem_ready,
//   o_mem_addr, o_mem_data        frame-memory write port (valid/ready)
//   o_bank                        bank currently being written
//   o_frame_done                  pulse after the last pixel of a frame is written
//   o_err_short                   pulse after a start-of-frame that cut a frame short
//   o_drop                        pulse for each pixel discarded outside a frame
module obuf_reader
    import obuf_reader_pkg::*;
#(
    parameter int DATA_WIDTH = CAM_DATA_WIDTH,
    parameter int H_ACTIVE   = CAM_H_ACTIVE,
    parameter int V_ACTIVE   = CAM_V_ACTIVE,
    parameter int ADDR_WIDTH = CAM_ADDR_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic                  i_enable,
    input  logic                  i_sof,
    output logic                  o_obuf_rd,
    input  logic [DATA_WIDTH-1:0] i_obuf_data,
    input  logic                  i_obuf_empty,
    output logic                  o_mem_wr,
    input  logic                  i_mem_ready,
    output logic [ADDR_WIDTH-1:0] o_mem_addr,
    output logic [DATA_WIDTH-1:0] o_mem_data,
    output logic                  o_bank,
    output logic                  o_frame_done,
    output logic                  o_err_short,
    output logic                  o_drop
);

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_SOF = 2'd1,
        ST_ACTIVE   = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
        ADDR_WIDTH'(frame_pixels(H_ACTIVE, V_ACTIVE) - 1);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH-1:0] count_q, count_d;
    logic                  bank_q, bank_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic                  inflight_q, inflight_d;

    logic                  head_valid;
    logic [DATA_WIDTH-1:0] head_data;
    logic [1:0]            occupancy;
    logic [1:0]            occ_after_pop;
    logic                  accept;
    logic                  drop;
    logic                  pop;
    logic                  rd;

    obuf_skid2 #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .i_clk        (i_clk),
        .i_rstn       (i_rstn),
        .i_push       (inflight_q),
        .i_push_data  (i_obuf_data),
        .i_pop        (pop),
        .o_head_valid (head_valid),
        .o_head_data  (head_data),
        .o_occupancy  (occupancy)
    );

    always_comb begin
        accept        = (state_q == ST_ACTIVE) && head_valid && i_mem_ready;
        drop          = (state_q == ST_WAIT_SOF) && head_valid;
        pop           = accept || drop;
        occ_after_pop = occupancy - {1'b0, pop};
        // Counting the same-cycle pop keeps one read in flight per cycle for full rate;
        // a full skid never issues, so a stalled write port cannot overrun it.
        rd = (state_q != ST_IDLE) && !i_obuf_empty && (occupancy != 2'd2) &&
             ((occ_after_pop + {1'b0, inflight_q}) < 2'd2);
    end

    always_comb begin
        state_d    = state_q;
        count_d    = count_q;
        bank_d     = bank_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        inflight_d = rd;
        case (state_q)
            ST_IDLE: begin
                if (i_enable) begin
                    state_d = ST_WAIT_SOF;
                end
            end
            ST_WAIT_SOF: begin
                if (!i_enable) begin
                    state_d = ST_IDLE;
                end else if (i_sof) begin
                    state_d = ST_ACTIVE;
                    count_d = '0;
                end
            end
            ST_ACTIVE: begin
                if (accept && (count_q == LAST_ADDR)) begin
                    // Frame complete. A coincident sof opens the next frame right away.
                    count_d = '0;
                    done_d  = 1'b1;
                    bank_d  = ~bank_q;
                    if (i_sof) begin
                        state_d = ST_ACTIVE;
                    end else if (i_enable) begin
                        state_d = ST_WAIT_SOF;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (i_sof) begin
                    // Short frame: restart addressing, keep writing the same bank.
                    err_d   = 1'b1;
                    count_d = '0;
                end else if (accept) begin
                    count_d = count_q + ADDR_WIDTH'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            bank_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            inflight_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            bank_q     <= bank_d;
            done_q     <= done_d;
            err_q      <= err_d;
            inflight_q <= inflight_d;
        end
    end

    assign o_obuf_rd    = rd;
    assign o_mem_wr     = (state_q == ST_ACTIVE) && head_valid;
    assign o_mem_addr   = count_q;
    assign o_mem_data   = head_data;
    assign o_bank       = bank_q;
    assign o_frame_done = done_q;
    assign o_err_short  = err_q;
    assign o_drop       = drop;

endmodule

// File: tb/tb_obuf_reader.sv
module tb_obuf_reader;

    localparam int DW   = 12;
    localparam int H    = 8;
    localparam int V    = 4;
    localparam int AW   = 5;
    localparam int LAST = H * V - 1;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic          clk = 1'b0;
    logic          i_rstn = 1'b0;
    logic          i_enable = 1'b0;
    logic          i_sof = 1'b0;
    logic          o_obuf_rd;
    logic [DW-1:0] i_obuf_data = '0;
    logic          i_obuf_empty = 1'b1;
    logic          o_mem_wr;
    logic          i_mem_ready = 1'b1;
    logic [AW-1:0] o_mem_addr;
    logic [DW-1:0] o_mem_data;
    logic          o_bank;
    logic          o_frame_done;
    logic          o_err_short;
    logic          o_drop;

    obuf_reader #(
        .DATA_WIDTH (DW),
        .H_ACTIVE   (H),
        .V_ACTIVE   (V),
        .ADDR_WIDTH (AW)
    ) dut (
        .i_clk        (clk),
        .i_rstn       (i_rstn),
        .i_enable     (i_enable),
        .i_sof        (i_sof),
        .o_obuf_rd    (o_obuf_rd),
        .i_obuf_data  (i_obuf_data),
        .i_obuf_empty (i_obuf_empty),
        .o_mem_wr     (o_mem_wr),
        .i_mem_ready  (i_mem_ready),
        .o_mem_addr   (o_mem_addr),
        .o_mem_data   (o_mem_data),
        .o_bank       (o_bank),
        .o_frame_done (o_frame_done),
        .o_err_short  (o_err_short),
        .o_drop       (o_drop)
    );

    always #5 clk = ~clk;

    // Scoreboard of expected writes and the model of the upstream FIFO contents.
    exp_t          sb[$];
    logic [DW-1:0] fifo[$];

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int pend = 0;            // pixels read from the FIFO and not yet consumed
    bit infl = 1'b0;         // read issued in the previous cycle
    bit rd_prev = 1'b0;
    bit last_acc_prev = 1'b0;
    bit bank_m = 1'b0;
    int drop_cnt = 0, done_cnt = 0, err_cnt = 0, rd_cnt = 0, acc_cnt = 0;
    int acc_first = -1, acc_last = -1;
    int ready_mode = 0;      // 0: always ready, 1: ready one cycle in three, 2: never ready
    bit sof_now = 1'b0;
    bit sof_on_last = 1'b0;

    task automatic send(input int addr);
        logic [DW-1:0] d;
        exp_t e;
        d = DW'($urandom);
        fifo.push_back(d);
        if (addr >= 0) begin
            e.addr = AW'(addr);
            e.data = d;
            sb.push_back(e);
        end
        i_obuf_empty = 1'b0;
    endtask

    task automatic observe();
        exp_t e;
        int   occ;
        bit   accept;
        bit   last_now;
        accept   = o_mem_wr && i_mem_ready;
        last_now = 1'b0;
        if (last_acc_prev) bank_m = ~bank_m;
        vectors++;
        if (o_frame_done !== last_acc_prev) begin
            miscompares++;
            $display("FAIL frame_done cyc=%0d: got %b, required %b", cyc, o_frame_done, last_acc_prev);
        end
        vectors++;
        if (o_bank !== bank_m) begin
            miscompares++;
            $display("FAIL bank cyc=%0d: got %b, required %b", cyc, o_bank, bank_m);
        end
        if (o_mem_wr) begin
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_write cyc=%0d: got addr=%0d data=%03h, required no write",
                         cyc, o_mem_addr, o_mem_data);
            end else begin
                e = sb[0];
                if (o_mem_addr !== e.addr || o_mem_data !== e.data) begin
                    miscompares++;
                    $display("FAIL mem_write cyc=%0d: got addr=%0d data=%03h, required addr=%0d data=%03h",
                             cyc, o_mem_addr, o_mem_data, e.addr, e.data);
                end
                if (accept) begin
                    last_now = (int'(e.addr) == LAST);
                    void'(sb.pop_front());
                    $display("cyc=%0d write addr=%0d data=%03h bank=%b", cyc, o_mem_addr, o_mem_data, o_bank);
                end
            end
        end
        if (o_drop) begin
            drop_cnt++;
            $display("cyc=%0d drop data=%03h", cyc, o_mem_data);
            vectors++;
            if (o_mem_wr) begin
                miscompares++;
                $display("FAIL drop_with_write cyc=%0d: got o_mem_wr=1, required 0", cyc);
            end
        end
        if (o_err_short) err_cnt++;
        if (o_frame_done) done_cnt++;
        occ = pend - int'(infl);
        if (o_obuf_rd) begin
            rd_cnt++;
            vectors++;
            if (occ >= 2 || i_obuf_empty) begin
                miscompares++;
                $display("FAIL read_issue cyc=%0d: got rd=1 with skid=%0d empty=%b, required no read",
                         cyc, occ, i_obuf_empty);
            end
        end
        pend = pend + int'(o_obuf_rd) - int'(accept) - int'(o_drop);
        infl = o_obuf_rd;
        rd_prev = o_obuf_rd;
        last_acc_prev = last_now;
        if (accept) begin
            acc_cnt++;
            if (acc_first < 0) acc_first = cyc;
            acc_last = cyc;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        case (ready_mode)
            0:       i_mem_ready = 1'b1;
            1:       i_mem_ready = (cyc % 3 == 0);
            default: i_mem_ready = 1'b0;
        endcase
        if (sof_now) begin
            i_sof = 1'b1;
            sof_now = 1'b0;
        end else if (sof_on_last && o_mem_wr && i_mem_ready && int'(o_mem_addr) == LAST) begin
            i_sof = 1'b1;
            sof_on_last = 1'b0;
        end
        #1;
        observe();
        cyc++;
        @(posedge clk);
        #1;
        i_sof = 1'b0;
        if (rd_prev && fifo.size() > 0) i_obuf_data = fifo.pop_front();
        else i_obuf_data = DW'($urandom);
        i_obuf_empty = (fifo.size() == 0);
    endtask

    task automatic run_drain(input int limit);
        int n = 0;
        while ((sb.size() != 0 || fifo.size() != 0) && n < limit) begin
            tick();
            n++;
        end
        vectors++;
        if (sb.size() != 0 || fifo.size() != 0) begin
            miscompares++;
            $display("FAIL drain_timeout: got %0d writes and %0d pixels outstanding, required 0",
                     sb.size(), fifo.size());
            sb.delete();
        end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        int rd0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({o_obuf_rd, o_mem_wr, o_bank, o_frame_done, o_err_short, o_drop} !== 6'b0) begin
            miscompares++;
            $display("FAIL reset_ctrl: got rd/wr/bank/done/err/drop=%b, required 000000",
                     {o_obuf_rd, o_mem_wr, o_bank, o_frame_done, o_err_short, o_drop});
        end
        vectors++;
        if (o_mem_addr !== '0 || o_mem_data !== '0) begin
            miscompares++;
            $display("FAIL reset_addr_data: got addr=%0d data=%03h, required 0/000", o_mem_addr, o_mem_data);
        end
        @(posedge clk);
        #1;
        i_rstn = 1'b1;
        // Idle with data waiting: no reads may be issued.
        rd0 = rd_cnt;
        repeat (3) send(-1);
        repeat (4) tick();
        vectors++;
        if (rd_cnt != rd0) begin
            miscompares++;
            $display("FAIL idle_no_read: got %0d reads, required 0", rd_cnt - rd0);
        end
    endtask

    task automatic test_drop_before_sof();
        int d0 = drop_cnt;
        int a0 = acc_cnt;
        i_enable = 1'b1;
        repeat (2) send(-1);
        run_drain(100);
        vectors++;
        if (drop_cnt - d0 != 5) begin
            miscompares++;
            $display("FAIL drop_count: got %0d, required 5", drop_cnt - d0);
        end
        vectors++;
        if (acc_cnt != a0) begin
            miscompares++;
            $display("FAIL drop_no_write: got %0d writes, required 0", acc_cnt - a0);
        end
        sof_now = 1'b1;
        tick();
    endtask

    task automatic test_full_frame();
        int d0 = done_cnt;
        int a0 = acc_cnt;
        acc_first = -1;
        for (int i = 0; i <= LAST; i++) send(i);
        run_drain(300);
        vectors++;
        if (acc_cnt - a0 != LAST + 1 || acc_last - acc_first != LAST) begin
            miscompares++;
            $display("FAIL full_rate: got %0d writes over %0d cycles, required %0d over %0d",
                     acc_cnt - a0, acc_last - acc_first + 1, LAST + 1, LAST + 1);
        end
        vectors++;
        if (done_cnt - d0 != 1) begin
            miscompares++;
            $display("FAIL full_done: got %0d, required 1", done_cnt - d0);
        end
        vectors++;
        if (o_bank !== 1'b1) begin
            miscompares++;
            $display("FAIL full_bank: got %b, required 1", o_bank);
        end
    endtask

    task automatic test_backpressure();
        int d0 = done_cnt;
        int p0 = drop_cnt;
        ready_mode = 1;
        sof_now = 1'b1;
        tick();
        for (int i = 0; i <= LAST; i++) send(i);
        repeat (2) send(-1);
        run_drain(600);
        ready_mode = 0;
        vectors++;
        if (done_cnt - d0 != 1 || drop_cnt - p0 != 2) begin
            miscompares++;
            $display("FAIL bp_counts: got done=%0d drops=%0d, required done=1 drops=2",
                     done_cnt - d0, drop_cnt - p0);
        end
        vectors++;
        if (o_bank !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_bank: got %b, required 0", o_bank);
        end
    endtask

    task automatic test_sof_on_last();
        int d0 = done_cnt;
        int e0 = err_cnt;
        int p0 = drop_cnt;
        sof_now = 1'b1;
        tick();
        for (int i = 0; i <= LAST; i++) send(i);
        for (int i = 0; i < 4; i++) send(i);
        sof_on_last = 1'b1;
        run_drain(300);
        vectors++;
        if (sof_on_last) begin
            miscompares++;
            $display("FAIL sof_align: got no sof at last accept, required one");
            sof_on_last = 1'b0;
        end
        vectors++;
        if (done_cnt - d0 != 1 || err_cnt != e0 || drop_cnt != p0) begin
            miscompares++;
            $display("FAIL sof_last_counts: got done=%0d err=%0d drops=%0d, required 1/0/0",
                     done_cnt - d0, err_cnt - e0, drop_cnt - p0);
        end
        vectors++;
        if (o_bank !== 1'b1) begin
            miscompares++;
            $display("FAIL sof_last_bank: got %b, required 1", o_bank);
        end
    endtask

    task automatic test_short_frame();
        int e0 = err_cnt;
        int d0 = done_cnt;
        for (int i = 4; i < 10; i++) send(i);
        run_drain(100);
        sof_now = 1'b1;
        tick();
        tick();
        vectors++;
        if (err_cnt - e0 != 1 || done_cnt != d0) begin
            miscompares++;
            $display("FAIL short_err: got err=%0d done=%0d, required err=1 done=0",
                     err_cnt - e0, done_cnt - d0);
        end
        for (int i = 0; i < 6; i++) send(i);
        run_drain(100);
        vectors++;
        if (o_bank !== 1'b1) begin
            miscompares++;
            $display("FAIL short_bank: got %b, required 1", o_bank);
        end
    endtask

    task automatic test_reset_mid_frame();
        int r0 = rd_cnt;
        ready_mode = 2;
        for (int i = 6; i < 12; i++) send(i);
        repeat (8) tick();
        vectors++;
        if (rd_cnt - r0 != 2 || o_mem_wr !== 1'b1 || o_mem_addr !== AW'(6)) begin
            miscompares++;
            $display("FAIL stall_fill: got reads=%0d wr=%b addr=%0d, required reads=2 wr=1 addr=6",
                     rd_cnt - r0, o_mem_wr, o_mem_addr);
        end
        @(negedge clk);
        #2;
        i_rstn = 1'b0;
        #1;
        vectors++;
        if ({o_obuf_rd, o_mem_wr, o_bank, o_frame_done, o_err_short, o_drop} !== 6'b0 ||
            o_mem_addr !== '0 || o_mem_data !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got rd/wr/bank/done/err/drop=%b addr=%0d data=%03h, required all 0",
                     {o_obuf_rd, o_mem_wr, o_bank, o_frame_done, o_err_short, o_drop}, o_mem_addr, o_mem_data);
        end
        sb.delete();
        fifo.delete();
        i_obuf_empty = 1'b1;
        pend = 0;
        infl = 1'b0;
        rd_prev = 1'b0;
        last_acc_prev = 1'b0;
        bank_m = 1'b0;
        i_enable = 1'b0;
        ready_mode = 0;
        @(posedge clk);
        #1;
        i_rstn = 1'b1;
        r0 = rd_cnt;
        send(-1);
        repeat (4) tick();
        vectors++;
        if (rd_cnt != r0 || o_bank !== 1'b0) begin
            miscompares++;
            $display("FAIL post_reset_idle: got reads=%0d bank=%b, required reads=0 bank=0",
                     rd_cnt - r0, o_bank);
        end
    endtask

    initial begin
        test_reset();
        test_drop_before_sof();
        test_full_frame();
        test_backpressure();
        test_sof_on_last();
        test_short_frame();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
